// File: rtl/adaptive_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adaptive_rr_arbiter_pkg
// Purpose  : Shared constants, state encoding and helpers for the RR arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package adaptive_rr_arbiter_pkg;

    localparam int MODE_ROTATE = 0;
    localparam int MODE_STICKY = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Elaboration-time ceil(log2(value)); clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adaptive_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector: rotate, find first, rotate back.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int CH = 4,
    parameter int IW = $clog2(CH)
) (
    input  logic [CH-1:0] i_eff,
    input  logic [IW-1:0] i_last_idx,
    output logic [CH-1:0] o_pick,
    output logic [IW-1:0] o_pick_idx,
    output logic          o_any
);

    localparam int SW = IW + 1;

    logic [2*CH-1:0] w_dbl;
    logic [CH-1:0]   w_rot;
    logic [SW-1:0]   w_shift;
    logic [SW-1:0]   w_ffs;
    logic            w_found;
    logic [SW:0]     w_sum;
    logic [SW:0]     w_idx_full;

    // Bit 0 of w_rot is channel last+1, so the owner itself lands in the top bit.
    assign w_dbl   = {i_eff, i_eff};
    assign w_shift = SW'(i_last_idx) + SW'(1);
    assign w_rot   = w_dbl[w_shift +: CH];

    always_comb begin
        w_ffs   = '0;
        w_found = 1'b0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_ffs   = SW'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_sum      = {1'b0, w_shift} + {1'b0, w_ffs};
    assign w_idx_full = (w_sum >= (SW+1)'(CH)) ? (w_sum - (SW+1)'(CH)) : w_sum;

    assign o_any      = w_found;
    assign o_pick_idx = w_found ? w_idx_full[IW-1:0] : '0;
    assign o_pick     = w_found ? (CH'(1) << o_pick_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/adaptive_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adaptive_rr_arbiter
// Purpose  : Registered round-robin arbiter with transaction hold and burst quantum.
// Revision : 1.0 - initial release
// ============================================================================
module adaptive_rr_arbiter
    import adaptive_rr_arbiter_pkg::*;
#(
    parameter int CH      = 4,
    parameter int MODE    = 0,
    parameter int QUANTUM = 4,
    parameter int IW      = $clog2(CH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [CH-1:0] Req_In,
    input  logic [CH-1:0] Mask_In,
    input  logic          Done_In,
    output logic [CH-1:0] Gnt_Out,
    output logic          Gnt_Vld,
    output logic [IW-1:0] Gnt_Idx,
    output logic          Gnt_Chg
);

    localparam int BW = clog2(QUANTUM + 1);

    state_t        r_state, w_nxt_state;
    logic [CH-1:0] r_gnt,   w_nxt_gnt;
    logic          r_vld;
    logic [IW-1:0] r_idx,   w_nxt_idx;
    logic [IW-1:0] r_last,  w_nxt_last;
    logic [BW-1:0] r_burst, w_nxt_burst;
    logic          r_chg,   w_nxt_chg;

    logic [CH-1:0] w_eff;
    logic [CH-1:0] w_pick;
    logic [IW-1:0] w_pick_idx;
    logic          w_any;
    logic          w_keep;

    assign w_eff = Req_In & Mask_In;

    rr_pick #(
        .CH (CH),
        .IW (IW)
    ) u_pick (
        .i_eff      (w_eff),
        .i_last_idx (r_last),
        .o_pick     (w_pick),
        .o_pick_idx (w_pick_idx),
        .o_any      (w_any)
    );

    // Sticky owner keeps the grant until its quantum of transactions is used.
    assign w_keep = (MODE == MODE_STICKY) && w_eff[r_idx] && (r_burst < BW'(QUANTUM));

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = r_gnt;
        w_nxt_idx   = r_idx;
        w_nxt_last  = r_last;
        w_nxt_burst = r_burst;
        w_nxt_chg   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_nxt_state = ST_BUSY;
                    w_nxt_gnt   = w_pick;
                    w_nxt_idx   = w_pick_idx;
                    w_nxt_last  = w_pick_idx;
                    w_nxt_burst = BW'(1);
                    w_nxt_chg   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (Done_In) begin
                    if (w_keep) begin
                        w_nxt_burst = r_burst + BW'(1);
                    end else if (!w_any) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_gnt   = '0;
                        w_nxt_idx   = '0;
                    end else begin
                        w_nxt_gnt   = w_pick;
                        w_nxt_idx   = w_pick_idx;
                        w_nxt_last  = w_pick_idx;
                        w_nxt_burst = BW'(1);
                        w_nxt_chg   = (w_pick_idx != r_idx);
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_gnt   = '0;
                w_nxt_idx   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_vld   <= 1'b0;
            r_idx   <= '0;
            r_last  <= IW'(CH - 1);
            r_burst <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_gnt   <= w_nxt_gnt;
            r_vld   <= |w_nxt_gnt;
            r_idx   <= w_nxt_idx;
            r_last  <= w_nxt_last;
            r_burst <= w_nxt_burst;
            r_chg   <= w_nxt_chg;
        end
    end

    assign Gnt_Out = r_gnt;
    assign Gnt_Vld = r_vld;
    assign Gnt_Idx = r_idx;
    assign Gnt_Chg = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_adaptive_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adaptive_rr_arbiter
// Purpose  : Scoreboard bench for rotate (MODE 0) and sticky (MODE 1, Q=2) arbiters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adaptive_rr_arbiter;

    localparam int CH = 4;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [CH-1:0] Req_In  = '0;
    logic [CH-1:0] Mask_In = '0;
    logic          Done_In = 1'b0;

    logic [CH-1:0] gnt_r, gnt_s;
    logic          vld_r, vld_s;
    logic [1:0]    idx_r, idx_s;
    logic          chg_r, chg_s;

    adaptive_rr_arbiter #(.CH(CH), .MODE(0), .QUANTUM(4)) u_rot (
        .Clk(Clk), .Rst(Rst), .Req_In(Req_In), .Mask_In(Mask_In), .Done_In(Done_In),
        .Gnt_Out(gnt_r), .Gnt_Vld(vld_r), .Gnt_Idx(idx_r), .Gnt_Chg(chg_r)
    );

    adaptive_rr_arbiter #(.CH(CH), .MODE(1), .QUANTUM(2)) u_stk (
        .Clk(Clk), .Rst(Rst), .Req_In(Req_In), .Mask_In(Mask_In), .Done_In(Done_In),
        .Gnt_Out(gnt_s), .Gnt_Vld(vld_s), .Gnt_Idx(idx_s), .Gnt_Chg(chg_s)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] g0; logic v0; logic [1:0] i0; logic c0;
        logic [3:0] g1; logic v1; logic [1:0] i1; logic c1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: owner -1 means idle; index 0 = rotate DUT, 1 = sticky DUT.
    int m_mode  [2] = '{0, 1};
    int m_quant [2] = '{4, 2};
    int owner   [2];
    int last    [2];
    int burst   [2];
    bit chg     [2];

    function automatic int rr_next(logic [3:0] eff, int from);
        for (int k = 1; k <= CH; k++) begin
            int c;
            c = (from + k) % CH;
            if (eff[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i] = -1; last[i] = CH - 1; burst[i] = 0; chg[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] eff, input bit done);
        for (int i = 0; i < 2; i++) begin
            int p;
            chg[i] = 1'b0;
            if (owner[i] < 0) begin
                p = rr_next(eff, last[i]);
                if (p >= 0) begin
                    owner[i] = p; last[i] = p; burst[i] = 1; chg[i] = 1'b1;
                end
            end else if (done) begin
                if (m_mode[i] == 1 && eff[owner[i]] && burst[i] < m_quant[i]) begin
                    burst[i]++;
                end else begin
                    p = rr_next(eff, last[i]);
                    if (p < 0) begin
                        owner[i] = -1;
                    end else begin
                        chg[i]   = (p != owner[i]);
                        owner[i] = p; last[i] = p; burst[i] = 1;
                    end
                end
            end
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.g0 = (owner[0] < 0) ? 4'h0 : 4'(1 << owner[0]);
        e.v0 = (owner[0] >= 0);
        e.i0 = (owner[0] < 0) ? 2'd0 : 2'(owner[0]);
        e.c0 = chg[0];
        e.g1 = (owner[1] < 0) ? 4'h0 : 4'(1 << owner[1]);
        e.v1 = (owner[1] >= 0);
        e.i1 = (owner[1] < 0) ? 2'd0 : 2'(owner[1]);
        e.c1 = chg[1];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_gnt_rot", 32'(gnt_r), 0); chk("rst_vld_rot", 32'(vld_r), 0);
        chk("rst_idx_rot", 32'(idx_r), 0); chk("rst_chg_rot", 32'(chg_r), 0);
        chk("rst_gnt_stk", 32'(gnt_s), 0); chk("rst_vld_stk", 32'(vld_s), 0);
        chk("rst_idx_stk", 32'(idx_s), 0); chk("rst_chg_stk", 32'(chg_s), 0);
    endtask

    task automatic cycle(input logic [3:0] req, input logic [3:0] mask, input bit done);
        @(negedge Clk);
        Rst     = 1'b0;
        Req_In  = req;
        Mask_In = mask;
        Done_In = done;
        model_step(req & mask, done);
        q.push_back(snapshot());
    endtask

    // Reset lands between clock edges; the grant must clear without waiting for Clk.
    task automatic async_reset();
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1 chk_reset_outputs();
        model_reset();
        q.push_back(snapshot());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt_rot", 32'(gnt_r), 32'(e.g0)); chk("vld_rot", 32'(vld_r), 32'(e.v0));
                chk("idx_rot", 32'(idx_r), 32'(e.i0)); chk("chg_rot", 32'(chg_r), 32'(e.c0));
                chk("gnt_stk", 32'(gnt_s), 32'(e.g1)); chk("vld_stk", 32'(vld_s), 32'(e.v1));
                chk("idx_stk", 32'(idx_s), 32'(e.i1)); chk("chg_stk", 32'(chg_s), 32'(e.c1));
            end
        end
    end

    initial begin : stimulus
        #1 Rst = 1'b1;
        #1 chk_reset_outputs();
        model_reset();

        // Full request, transaction length 3.
        for (int c = 0; c < 15; c++) cycle(4'hF, 4'hF, (c > 0) && (c % 3 == 0));

        async_reset();
        for (int c = 0; c < 8; c++) cycle(4'b0101, 4'hF, 1'b1);

        async_reset();
        cycle(4'b0010, 4'hF, 1'b0);
        for (int c = 0; c < 5; c++) cycle(4'b0010, 4'hF, 1'b1);

        // Owner drops its request mid-transaction, then completes with nobody waiting.
        async_reset();
        cycle(4'b0100, 4'hF, 1'b0);
        for (int c = 0; c < 4; c++) cycle(4'b0000, 4'hF, 1'b0);
        cycle(4'b0000, 4'hF, 1'b1);
        cycle(4'b0000, 4'hF, 1'b0);

        async_reset();
        for (int c = 0; c < 6; c++) cycle(4'b1010, 4'b1000, c[0]);

        cycle(4'hF, 4'hF, 1'b1);
        cycle(4'hF, 4'hF, 1'b0);
        async_reset();
        for (int c = 0; c < 3; c++) cycle(4'hF, 4'hF, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            logic [3:0] req, mask;
            bit done;
            req  = 4'($urandom);
            mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            done = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) async_reset();
            else cycle(req, mask, done);
        end

        cycle(4'h0, 4'hF, 1'b1);
        cycle(4'h0, 4'hF, 1'b0);
        @(negedge Clk);
        chk("queue_drained", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adaptive_rr_arbiter.md
# adaptive_rr_arbiter

Sequential round-robin arbiter with a registered one-hot grant, a transaction handshake and a per-grant burst quantum. It extends the combinational adaptive selector in two ways. The grant is held across a multi-cycle transaction. In sticky mode, a channel can no longer keep the grant indefinitely. It sits in front of shared resources (bus master port, shared FIFO write side) and arbitrates CH requesters.

## Interface
- CH, default 4: number of requesting channels, legal range 2..32.
- MODE, default 0: 0 = rotate after every completed transaction; 1 = sticky, the current owner keeps the grant while it still requests, limited by QUANTUM.
- QUANTUM, default 4: maximum consecutive transactions per grant in MODE 1, legal range 1..255; ignored in MODE 0.
- IW, default $clog2(CH): width of the index output.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- Req_In  in  CH  per-channel request, active high, level.
- Mask_In  in  CH  per-channel enable, active high; a request counts only when Req_In&Mask_In.
- Done_In  in  1  one-cycle pulse from the owner: current transaction complete. Ignored when Gnt_Vld=0.
- Gnt_Out  out  CH  registered one-hot grant; all zero when idle.
- Gnt_Vld  out  1  registered, equal to |Gnt_Out.
- Gnt_Idx  out  IW  binary index of the granted channel; 0 when idle.
- Gnt_Chg  out  1  one-cycle pulse in the cycle Gnt_Out takes a new nonzero value.

## Operation
- Effective request: Eff = Req_In & Mask_In.
- State machine with two states:
  - IDLE: no owner.
  - BUSY: Gnt_Out holds the owner.
- Priority pointer Last_Idx holds the index of the most recent owner. Search order is Last_Idx+1, Last_Idx+2, … modulo CH, wrapping from CH-1 to 0. Last_Idx itself is last in the order.
- IDLE:
  - If Eff≠0, pick the first set bit in the search order.
  - Register the grant, set Burst_Cnt=1, update Last_Idx, go to BUSY.
  - If Eff=0, stay in IDLE.
- BUSY without Done_In: the grant is frozen. Changes in Req_In or Mask_In, including the owner dropping its request, have no effect.
- BUSY with Done_In, MODE 0:
  - Pick the next channel in the search order among Eff.
  - The owner is eligible only if it is the sole requester, in which case it is re-granted.
- BUSY with Done_In, MODE 1:
  - If Eff[owner]=1 and Burst_Cnt<QUANTUM, keep the owner and increment Burst_Cnt.
  - Otherwise rotate exactly as in MODE 0.
  - If the owner is the sole requester it is re-granted even at quantum; Burst_Cnt restarts at 1.
- On any handover to a different channel, Burst_Cnt becomes 1 and Gnt_Chg pulses.
- If Done_In arrives with Eff=0, Gnt_Out goes to 0 and the state returns to IDLE. Last_Idx is kept.
- Burst_Cnt width is $clog2(QUANTUM+1). It saturates and never wraps.

## Timing
- Reset values:
  - Gnt_Out=0, Gnt_Vld=0, Gnt_Idx=0, Gnt_Chg=0.
  - State IDLE, Burst_Cnt=0.
  - Last_Idx=CH-1, so channel 0 has first priority after reset.
- Grant latency from IDLE: Eff sampled at edge N gives Gnt_Out valid after edge N. This is one cycle of latency.
- Handover on Done_In has zero bubble: Done_In sampled at edge N gives the new Gnt_Out after edge N.
- Gnt_Chg is high in the same cycle as the changed Gnt_Out.
- Re-grant to the same owner does not pulse Gnt_Chg unless the state came from IDLE.
- An async Rst asserted mid-transaction clears the grant immediately. After deassertion, arbitration restarts from channel 0 priority.
- Done_In in IDLE is ignored. Done_In and a Mask change in the same cycle: the new mask applies to the next pick.

## Structure
- Shared package holds:
  - the mode constants MODE_ROTATE=0 and MODE_STICKY=1;
  - the state encoding ST_IDLE and ST_BUSY;
  - a constant clog2 function.
- One combinational sub-module, rr_pick (parameter CH):
  - inputs Eff and Last_Idx;
  - outputs a one-hot Pick, its index, and Any.
  - Implementation: rotate, find first set bit, then rotate back.
- The top holds the FSM, Burst_Cnt, Last_Idx and the output registers. It instantiates rr_pick once.

## Test plan
1. Reset, CH=4, MODE=0. Req_In=4'b1111 with Done_In pulsed every 3 cycles. Required: Gnt_Idx sequence 0,1,2,3,0 with each grant held 3 cycles and Gnt_Chg on every handover.
2. MODE=1, QUANTUM=2, Req_In=4'b0101 held, Done_In every cycle. Required: grants 0,0,2,2,0,0.
3. MODE=1, only channel 1 requesting, 5 Done_In pulses. Required: Gnt_Idx stays 1 and Gnt_Chg never pulses after the initial grant.
4. Owner 2 drops Req_In mid-transaction with no Done_In for 4 cycles. Required: Gnt_Out stays 4'b0100. Then Done_In with Req_In=0. Required: next cycle Gnt_Out=0 and Gnt_Vld=0.
5. Req_In=4'b1010, Mask_In=4'b1000. Required: first grant is channel 3 and channel 1 is never granted.
6. Rst asserted asynchronously mid-grant. Required: Gnt_Out=0 immediately. After release with Req_In=4'b1111, the first grant is channel 0.
